// File: rtl/sliding_window_gather_pkg.sv
// Shared window constants and helpers for the im2col gather and weight generation.
// Pure declarations; no state, no latency, no flow control.
package sliding_window_gather_pkg;

  // Flattened position of window element (ky,kx,c) for a KxK window of C channels.
  function automatic int window_index(input int ky, input int kx, input int c,
                                      input int k, input int ch);
    return (ky * k + kx) * ch + c;
  endfunction

endpackage

// File: rtl/sliding_window_gather_line_buffer.sv
// One-row pixel delay: tap_dat is the pixel pushed Depth enables ago.
// Latency: Depth enabled cycles. Backpressure: none; advances only when enable is high.
// The tap is a combinational read of the slot that the next push overwrites.
module sliding_window_gather_line_buffer
  import sliding_window_gather_pkg::*;
#(
  parameter int Depth = 32,
  parameter int Width = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [Width-1:0] push_dat,
  output logic [Width-1:0] tap_dat
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  ptr;

  assign tap_dat = mem[ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (enable) begin
      ptr <= (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (enable) begin
      mem[ptr] <= push_dat;
    end
  end

endmodule

// File: rtl/sliding_window_gather.sv
// Stride-1, unpadded KxK im2col gather over a raster pixel stream.
// Latency 1: window for accepted pixel (r,x) is valid the next cycle.
// Backpressure: slave_ready_o = !master_valid_o || master_ready_i; output holds while stalled.
module sliding_window_gather
  import sliding_window_gather_pkg::*;
#(
  parameter int ImageWidth      = 32,
  parameter int ImageHeight     = 32,
  parameter int KernelSize      = 7,
  parameter int Channels        = 3,
  parameter int ActivationWidth = 8,
  localparam int OutChannels    = KernelSize * KernelSize * Channels
) (
  input  logic                                   clock_i,
  input  logic                                   reset_i,
  input  logic                                   slave_valid_i,
  output logic                                   slave_ready_o,
  input  logic [Channels*ActivationWidth-1:0]    slave_data_i,
  output logic                                   master_valid_o,
  input  logic                                   master_ready_i,
  output logic [OutChannels*ActivationWidth-1:0] master_data_o
);

  localparam int PixW = Channels * ActivationWidth;
  localparam int ColW = (ImageWidth > 1) ? $clog2(ImageWidth) : 1;
  localparam int RowW = (ImageHeight > 1) ? $clog2(ImageHeight) : 1;
  localparam logic [ColW-1:0] LastCol = ColW'(ImageWidth - 1);
  localparam logic [RowW-1:0] LastRow = RowW'(ImageHeight - 1);

  if (KernelSize < 1) begin : g_bad_kernel
    $error("sliding_window_gather: KernelSize must be at least 1");
  end
  if (ImageWidth < KernelSize) begin : g_bad_width
    $error("sliding_window_gather: ImageWidth must be >= KernelSize");
  end
  if (ImageHeight < KernelSize) begin : g_bad_height
    $error("sliding_window_gather: ImageHeight must be >= KernelSize");
  end

  typedef logic [PixW-1:0] pixel_t;

  pixel_t          win    [KernelSize][KernelSize];
  pixel_t          col_in [KernelSize];
  logic [ColW-1:0] col;
  logic [RowW-1:0] row;
  logic            valid_q;
  logic            accept;
  logic            emit;

  assign master_valid_o = valid_q;
  assign slave_ready_o  = !valid_q || master_ready_i;
  assign accept         = slave_valid_i && slave_ready_o;
  assign emit           = (int'(row) >= KernelSize - 1) && (int'(col) >= KernelSize - 1);

  // Bottom window row is the live pixel; each line buffer up the chain adds one row of delay.
  assign col_in[KernelSize-1] = slave_data_i;

  for (genvar i = 0; i < KernelSize - 1; i++) begin : g_line
    sliding_window_gather_line_buffer #(
      .Depth (ImageWidth),
      .Width (PixW)
    ) u_line_buffer (
      .clock    (clock_i),
      .reset    (reset_i),
      .enable   (accept),
      .push_dat (col_in[KernelSize-1-i]),
      .tap_dat  (col_in[KernelSize-2-i])
    );
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      col     <= '0;
      row     <= '0;
      valid_q <= 1'b0;
    end else begin
      if (accept) begin
        valid_q <= emit;
        if (col == LastCol) begin
          col <= '0;
          row <= (row == LastRow) ? '0 : row + RowW'(1);
        end else begin
          col <= col + ColW'(1);
        end
      end else if (master_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  // The window array only moves on accept, so it doubles as the held output register.
  always_ff @(posedge clock_i) begin
    if (accept) begin
      for (int ky = 0; ky < KernelSize; ky++) begin
        for (int kx = 0; kx < KernelSize - 1; kx++) begin
          win[ky][kx] <= win[ky][kx+1];
        end
        win[ky][KernelSize-1] <= col_in[ky];
      end
    end
  end

  always_comb begin
    master_data_o = '0;
    for (int ky = 0; ky < KernelSize; ky++) begin
      for (int kx = 0; kx < KernelSize; kx++) begin
        for (int c = 0; c < Channels; c++) begin
          master_data_o[window_index(ky, kx, c, KernelSize, Channels)*ActivationWidth +: ActivationWidth]
            = win[ky][kx][c*ActivationWidth +: ActivationWidth];
        end
      end
    end
  end

endmodule

// File: doc/sliding_window_gather.md
SLIDING_WINDOW_GATHER -- requirements
Module: sliding_window_gather

Interface
REQ-001 Parameter ImageWidth, default 32: pixels per input row; elaboration SHALL fail if ImageWidth < KernelSize.
REQ-002 Parameter ImageHeight, default 32: rows per frame; elaboration SHALL fail if ImageHeight < KernelSize.
REQ-003 Parameter KernelSize, default 7: square window edge K; K >= 1.
REQ-004 Parameter Channels, default 3: channels per input pixel C.
REQ-005 Parameter ActivationWidth, default 8: bits per activation.
REQ-006 Derived OutChannels = K*K*C (default 147), matching pointwise_convolve InChannels.
REQ-007 clock_i  input  1  single clock; all state on rising edge.
REQ-008 reset_i  input  1  reset, asynchronous and active-high.
REQ-009 slave_valid_i  input  1  input pixel valid.
REQ-010 slave_ready_o  output  1  input pixel accepted when valid and ready are both high.
REQ-011 slave_data_i  input  C x ActivationWidth  one pixel, index 0 = channel 0.
REQ-012 master_valid_o  output  1  output window valid.
REQ-013 master_ready_i  input  1  downstream (pointwise_convolve) ready.
REQ-014 master_data_o  output  OutChannels x ActivationWidth  flattened window.

Function
REQ-015 Input SHALL be raster order: column x = 0..ImageWidth-1 within row r = 0..ImageHeight-1, frames back to back with no separator.
REQ-016 Column and row counters SHALL advance only on accepted pixels; col wraps ImageWidth-1 -> 0 incrementing row; row wraps ImageHeight-1 -> 0 (new frame).
REQ-017 Stride 1, no padding: a window SHALL be emitted exactly for accepted pixels with r >= K-1 and x >= K-1; (ImageHeight-K+1)*(ImageWidth-K+1) windows per frame.
REQ-018 Emitted window has bottom-right corner at the accepted pixel (r,x); element (ky,kx,c) = pixel (r-K+1+ky, x-K+1+kx) channel c.
REQ-019 Flattened index of element (ky,kx,c) SHALL be (ky*K + kx)*C + c.
REQ-020 Window SHALL appear on master_data_o with master_valid_o high on the cycle after the accepting clock edge (latency 1).
REQ-021 master_valid_o and master_data_o SHALL hold stable while master_valid_o = 1 and master_ready_i = 0.
REQ-022 slave_ready_o = !master_valid_o || master_ready_i (combinational); an accept and an output drain on the same edge SHALL sustain one pixel per cycle.
REQ-023 Pixels that produce no window SHALL still require slave_ready_o and update line buffers and window registers.
REQ-024 Window registers from previous rows/frames SHALL never leak: first window of each frame uses only that frame's pixels.
REQ-025 K = 1: every accepted pixel SHALL be passed through as a window of C elements.

Reset
REQ-026 On reset_i high: master_valid_o = 0, col = 0, row = 0, asynchronously; slave_ready_o = 1 after reset.
REQ-027 Line buffer and window register contents SHALL NOT require reset (not observable per REQ-024).
REQ-028 Reset asserted mid-frame SHALL discard any pending output; the next accepted pixel is (0,0) of a new frame.

Structure
REQ-029 Function window_index(ky,kx,c,K,C) implementing REQ-019 SHALL live in the shared constants package for reuse by weight generation.
REQ-030 Sub-module line_buffer: one-row delay of ImageWidth entries, C*ActivationWidth wide, advanced by an enable; K-1 instances chained.
REQ-031 Window: K x K register array of pixels shifting left on accept; right column fed by line buffer taps (rows 0..K-2) and the input pixel (row K-1).

Verification
REQ-032 W=4,H=4,K=3,C=1, pixel = 4r+x, no stalls -> 4 windows; first after pixel 10 = {0,1,2,4,5,6,8,9,10}; last = {5,6,7,9,10,11,13,14,15}.
REQ-033 Same config, master_ready_i low 5 cycles while window {1,2,3,5,6,7,9,10,11} is valid -> data held, slave_ready_o = 0, no pixel lost.
REQ-034 Two frames back to back, frame 2 pixel = 100+4r+x -> first frame-2 window = {100,101,102,104,105,106,108,109,110}, no frame-1 values.
REQ-035 reset_i pulsed after pixel 9 of frame -> pending output dropped; next 16 pixels give the REQ-032 result exactly.
REQ-036 Default parameters (32x32,K=7,C=3) random pixels, random valid/ready gaps 0-10 cycles -> 676 windows matching golden im2col model, feeding pointwise_convolve end to end.
REQ-037 K=1, C=3 -> every pixel emitted unchanged one cycle after acceptance.
